// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for mem_port_arbiter: FSM states, owner encoding and default widths.
// Round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_port_arbiter_pkg;

  localparam int DEFAULT_AW = 8;
  localparam int DEFAULT_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational two-requester picker: fixed CPU priority by default,
// round-robin against last_owner when MEM_ARB_RR_EN is defined.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  owner_t last_owner,
`endif
  input  logic   cpu_req,
  input  logic   dma_req,
  output logic   grant,
  output owner_t owner
);

  always_comb begin
    grant = cpu_req | dma_req;
    owner = OWN_CPU;
    if (cpu_req && dma_req) begin
`ifdef MEM_ARB_RR_EN
      owner = other_owner(last_owner);
`else
      owner = OWN_CPU;
`endif
    end else if (dma_req) begin
      owner = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one ack-handshaked data-memory port between the CPU and the DMA loader.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise the CPU always wins a tie.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          cpu_req,
  input  logic          cpu_wr_en,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wr_data,
  output logic [DW-1:0] cpu_rd_data,
  output logic          cpu_ack,

  input  logic          dma_req,
  input  logic          dma_wr_en,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wr_data,
  output logic [DW-1:0] dma_rd_data,
  output logic          dma_ack,

  output logic          mem_req,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  input  logic          mem_ack
);

  state_t state;
  state_t state_nxt;
  owner_t owner_q;
  owner_t pick_owner;
  logic   pick_grant;
  logic   load;
  logic   capture;

`ifdef MEM_ARB_RR_EN
  owner_t last_owner;
`endif

  arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .grant      (pick_grant),
    .owner      (pick_owner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A grant is only evaluated in IDLE; DONE always spends one cycle on the ack.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_grant) begin
          load      = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_CPU;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      cpu_rd_data <= '0;
      dma_rd_data <= '0;
    end else begin
      if (load) begin
        owner_q <= pick_owner;
        if (pick_owner == OWN_CPU) begin
          mem_wr_en   <= cpu_wr_en;
          mem_addr    <= cpu_addr;
          mem_wr_data <= cpu_wr_data;
        end else begin
          mem_wr_en   <= dma_wr_en;
          mem_addr    <= dma_addr;
          mem_wr_data <= dma_wr_data;
        end
      end
      // Writes capture too; the requester simply ignores the returned word.
      if (capture) begin
        if (owner_q == OWN_CPU) begin
          cpu_rd_data <= mem_rd_data;
        end else begin
          dma_rd_data <= mem_rd_data;
        end
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= OWN_DMA;
    end else if (load) begin
      last_owner <= pick_owner;
    end
  end
`endif

  assign mem_req = (state == ST_BUSY);
  assign cpu_ack = (state == ST_DONE) && (owner_q == OWN_CPU);
  assign dma_ack = (state == ST_DONE) && (owner_q == OWN_DMA);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus a randomized
// phase checked against a transaction-level model of arbitration and memory.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_wr_en, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wr_data, cpu_rd_data;
  logic          dma_req, dma_wr_en, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wr_data, dma_rd_data;
  logic          mem_req, mem_wr_en, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;

  logic          auto_mem, man_ack, resp_ack;
  logic [DW-1:0] man_data, resp_data;
  int            resp_cnt;
  logic [DW-1:0] tb_mem    [256];
  logic [DW-1:0] model_mem [256];

  int     tests_run = 0;
  int     tests_failed = 0;
  bit     cpu_pend, dma_pend, timed_out, exp_dma;
  owner_t model_last, exp_owner;
  int     served, wait_cnt;

  always #5 clk = ~clk;

  assign mem_ack     = auto_mem ? resp_ack  : man_ack;
  assign mem_rd_data = auto_mem ? resp_data : man_data;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data),
    .cpu_ack     (cpu_ack),
    .dma_req     (dma_req),
    .dma_wr_en   (dma_wr_en),
    .dma_addr    (dma_addr),
    .dma_wr_data (dma_wr_data),
    .dma_rd_data (dma_rd_data),
    .dma_ack     (dma_ack),
    .mem_req     (mem_req),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_ack     (mem_ack)
  );

  // Memory responder with 0..2 cycles of random extra latency.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) tb_mem[i] = 32'hC0DE0000 + 32'(i);
      resp_ack  = 1'b0;
      resp_data = '0;
      resp_cnt  = 0;
    end else if (mem_req && !resp_ack && resp_cnt == 0) begin
      resp_ack  = 1'b1;
      resp_data = tb_mem[mem_addr];
      if (mem_wr_en) tb_mem[mem_addr] = mem_wr_data;
    end else begin
      resp_ack = 1'b0;
      if (!mem_req) resp_cnt = $urandom_range(0, 2);
      else if (resp_cnt > 0) resp_cnt--;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic applyStimulus();
    if (!cpu_pend && $urandom_range(0, 1) == 1) begin
      cpu_pend    = 1'b1;
      cpu_req     = 1'b1;
      cpu_wr_en   = 1'($urandom_range(0, 1));
      cpu_addr    = 8'($urandom_range(0, 15));
      cpu_wr_data = $urandom;
    end
    if (!dma_pend && $urandom_range(0, 1) == 1) begin
      dma_pend    = 1'b1;
      dma_req     = 1'b1;
      dma_wr_en   = 1'($urandom_range(0, 1));
      dma_addr    = 8'($urandom_range(0, 15));
      dma_wr_data = $urandom;
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_wr_en = 1'b0; cpu_addr = '0; cpu_wr_data = '0;
    dma_req = 1'b0; dma_wr_en = 1'b0; dma_addr = '0; dma_wr_data = '0;
    auto_mem = 1'b0; man_ack = 1'b0; man_data = '0;
    tick();
    tick();

    checkOutput("rst_mem_req",     32'(mem_req),     32'd0);
    checkOutput("rst_mem_wr_en",   32'(mem_wr_en),   32'd0);
    checkOutput("rst_mem_addr",    32'(mem_addr),    32'd0);
    checkOutput("rst_mem_wr_data", mem_wr_data,      32'd0);
    checkOutput("rst_cpu_rd_data", cpu_rd_data,      32'd0);
    checkOutput("rst_dma_rd_data", dma_rd_data,      32'd0);
    checkOutput("rst_cpu_ack",     32'(cpu_ack),     32'd0);
    checkOutput("rst_dma_ack",     32'(dma_ack),     32'd0);
    reset = 1'b0;
    tick();

    // Stray mem_ack while idle must be ignored.
    man_ack = 1'b1; man_data = 32'hAAAA5555;
    tick();
    checkOutput("idle_mem_req", 32'(mem_req), 32'd0);
    checkOutput("idle_cpu_ack", 32'(cpu_ack), 32'd0);
    checkOutput("idle_dma_ack", 32'(dma_ack), 32'd0);
    checkOutput("idle_cpu_rd",  cpu_rd_data,  32'd0);
    man_ack = 1'b0;
    tick();
    checkOutput("idle2_mem_req", 32'(mem_req), 32'd0);

    // Single CPU read, memory answers after two BUSY cycles.
    cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 8'h10;
    tick();
    checkOutput("rd_c1_mem_req",  32'(mem_req),   32'd1);
    checkOutput("rd_c1_mem_addr", 32'(mem_addr),  32'h10);
    checkOutput("rd_c1_wr_en",    32'(mem_wr_en), 32'd0);
    checkOutput("rd_c1_cpu_ack",  32'(cpu_ack),   32'd0);
    tick();
    checkOutput("rd_c2_mem_req",  32'(mem_req),   32'd1);
    man_ack = 1'b1; man_data = 32'hDEADBEEF;
    tick();
    checkOutput("rd_c3_cpu_ack",  32'(cpu_ack),   32'd1);
    checkOutput("rd_c3_cpu_rd",   cpu_rd_data,    32'hDEADBEEF);
    checkOutput("rd_c3_mem_req",  32'(mem_req),   32'd0);
    checkOutput("rd_c3_dma_ack",  32'(dma_ack),   32'd0);
    man_ack = 1'b0; cpu_req = 1'b0;
    tick();
    checkOutput("rd_c4_cpu_ack",  32'(cpu_ack),   32'd0);
    checkOutput("rd_c4_cpu_hold", cpu_rd_data,    32'hDEADBEEF);

    // DMA write acknowledged in the first BUSY cycle.
    dma_req = 1'b1; dma_wr_en = 1'b1; dma_addr = 8'h20; dma_wr_data = 32'h12345678;
    tick();
    checkOutput("wr_c1_mem_req",  32'(mem_req),   32'd1);
    checkOutput("wr_c1_wr_en",    32'(mem_wr_en), 32'd1);
    checkOutput("wr_c1_mem_addr", 32'(mem_addr),  32'h20);
    checkOutput("wr_c1_wr_data",  mem_wr_data,    32'h12345678);
    man_ack = 1'b1; man_data = 32'h0BADF00D;
    tick();
    checkOutput("wr_c2_dma_ack",  32'(dma_ack),   32'd1);
    checkOutput("wr_c2_mem_req",  32'(mem_req),   32'd0);
    checkOutput("wr_c2_cpu_ack",  32'(cpu_ack),   32'd0);
    checkOutput("wr_c2_cpu_hold", cpu_rd_data,    32'hDEADBEEF);
    man_ack = 1'b0; dma_req = 1'b0;
    tick();

    // CPU address changes mid-access; memory side must keep the granted one.
    cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 8'h05;
    tick();
    checkOutput("chg_c1_mem_addr", 32'(mem_addr), 32'h05);
    cpu_addr = 8'h06;
    tick();
    checkOutput("chg_c2_mem_addr", 32'(mem_addr), 32'h05);
    man_ack = 1'b1; man_data = 32'h00000055;
    tick();
    checkOutput("chg_c3_cpu_ack",  32'(cpu_ack),  32'd1);
    checkOutput("chg_c3_mem_addr", 32'(mem_addr), 32'h05);
    checkOutput("chg_c3_cpu_rd",   cpu_rd_data,   32'h00000055);
    man_ack = 1'b0; cpu_req = 1'b0;
    tick();

    // Reset in the middle of an access abandons it without an ack.
    cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 8'h30;
    tick();
    checkOutput("mid_c1_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    checkOutput("mid_rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("mid_rst_cpu_ack", 32'(cpu_ack), 32'd0);
    checkOutput("mid_rst_dma_ack", 32'(dma_ack), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("mid_idle_mem_req", 32'(mem_req), 32'd0);
    checkOutput("mid_idle_cpu_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b1; cpu_addr = 8'h31;
    tick();
    checkOutput("mid_new_mem_req",  32'(mem_req),  32'd1);
    checkOutput("mid_new_mem_addr", 32'(mem_addr), 32'h31);
    man_ack = 1'b1; man_data = 32'h31313131;
    tick();
    checkOutput("mid_new_cpu_ack", 32'(cpu_ack), 32'd1);
    checkOutput("mid_new_cpu_rd",  cpu_rd_data,  32'h31313131);
    man_ack = 1'b0; cpu_req = 1'b0;
    tick();

    // Both requesters held from reset for four accesses.
    doReset();
    cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 8'h40;
    dma_req = 1'b1; dma_wr_en = 1'b0; dma_addr = 8'h50;
    for (int i = 0; i < 4; i++) begin
      exp_dma = RR_BUILD && (i % 2 == 1);
      tick();
      checkOutput("tie_mem_addr", 32'(mem_addr), exp_dma ? 32'h50 : 32'h40);
      man_ack = 1'b1; man_data = 32'h1000 + 32'(i);
      tick();
      checkOutput("tie_cpu_ack", 32'(cpu_ack), 32'(!exp_dma));
      checkOutput("tie_dma_ack", 32'(dma_ack), 32'(exp_dma));
      man_ack = 1'b0;
      if (i == 3) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
      end
      tick();
    end

    // Randomized traffic against a transaction-level model.
    doReset();
    for (int i = 0; i < 256; i++) model_mem[i] = 32'hC0DE0000 + 32'(i);
    auto_mem   = 1'b1;
    cpu_pend   = 1'b0;
    dma_pend   = 1'b0;
    model_last = OWN_DMA;
    served     = 0;
    timed_out  = 1'b0;
    while (served < 60 && !timed_out) begin
      applyStimulus();
      if (!cpu_pend && !dma_pend) begin
        tick();
        continue;
      end
      if (cpu_pend && dma_pend)
        exp_owner = (RR_BUILD && model_last == OWN_CPU) ? OWN_DMA : OWN_CPU;
      else
        exp_owner = cpu_pend ? OWN_CPU : OWN_DMA;
      wait_cnt = 0;
      do begin
        tick();
        wait_cnt++;
      end while (!cpu_ack && !dma_ack && wait_cnt < 20);
      checkOutput("rand_ack_seen", 32'(cpu_ack | dma_ack), 32'd1);
      if (!(cpu_ack | dma_ack)) begin
        timed_out = 1'b1;
      end else begin
        checkOutput("rand_cpu_ack", 32'(cpu_ack), 32'(exp_owner == OWN_CPU));
        checkOutput("rand_dma_ack", 32'(dma_ack), 32'(exp_owner == OWN_DMA));
        if (cpu_ack) begin
          if (!cpu_wr_en) checkOutput("rand_cpu_rd", cpu_rd_data, model_mem[cpu_addr]);
          else model_mem[cpu_addr] = cpu_wr_data;
          cpu_req = 1'b0; cpu_pend = 1'b0; model_last = OWN_CPU;
        end else begin
          if (!dma_wr_en) checkOutput("rand_dma_rd", dma_rd_data, model_mem[dma_addr]);
          else model_mem[dma_addr] = dma_wr_data;
          dma_req = 1'b0; dma_pend = 1'b0; model_last = OWN_DMA;
        end
        served++;
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
